control_sequencer: RTL and testbench

//  Consumer of the one-hot step bus driven by stepper; together with the instruction register it forms the control unit.

---
 rtl/control_sequencer_pkg.sv | 70 +++++++
 rtl/control_sequencer_if.sv | 44 ++++
 rtl/control_sequencer_phase_gen.sv | 45 ++++
 rtl/control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_control_sequencer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/control_sequencer_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// Package : cpu_ctrl_pkg
// Shared encodings for the 8-bit CPU control unit.       Rev 1.0
// ------------------------------------------------------------------
package cpu_ctrl_pkg;

  // Step bit indices on the one-hot stepper bus ([5]=step1 .. [0]=step6)
  localparam int S1 = 5;
  localparam int S2 = 4;
  localparam int S3 = 3;
  localparam int S4 = 2;
  localparam int S5 = 1;
  localparam int S6 = 0;

  localparam logic [5:0] STEP1 = 6'b100000;
  localparam logic [5:0] STEP2 = 6'b010000;
  localparam logic [5:0] STEP3 = 6'b001000;
  localparam logic [5:0] STEP4 = 6'b000100;
  localparam logic [5:0] STEP5 = 6'b000010;
  localparam logic [5:0] STEP6 = 6'b000001;

  localparam int FLAG_C = 3;
  localparam int FLAG_A = 2;
  localparam int FLAG_E = 1;
  localparam int FLAG_Z = 0;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SHR = 3'd1;
  localparam logic [2:0] ALU_SHL = 3'd2;
  localparam logic [2:0] ALU_NOT = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_OR  = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_STORE = 3'd1;
  localparam logic [2:0] OP_DATA  = 3'd2;
  localparam logic [2:0] OP_JMPR  = 3'd3;
  localparam logic [2:0] OP_JMP   = 3'd4;
  localparam logic [2:0] OP_JMPIF = 3'd5;
  localparam logic [2:0] OP_CLF   = 3'd6;
  localparam logic [2:0] OP_IO    = 3'd7;

  typedef struct packed {
    logic [3:0] reg_en;
    logic [3:0] reg_set;
    logic       iar_en;
    logic       iar_set;
    logic       ram_en;
    logic       ram_set;
    logic       acc_en;
    logic       acc_set;
    logic       mar_set;
    logic       ir_set;
    logic       tmp_set;
    logic       flags_set;
    logic       bus1;
    logic [2:0] alu_op;
    logic       io_en;
    logic       io_set;
  } ctrl_t;

  function automatic logic is_onehot6(input logic [5:0] s);
    return (s != 6'd0) && ((s & (s - 6'd1)) == 6'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/control_sequencer_if.sv
`default_nettype none
// ------------------------------------------------------------------
// Interface : control_sequencer_if
// Step/IR/flags inputs and control strobes of the CPU control unit. Rev 1.0
// ------------------------------------------------------------------
interface control_sequencer_if;
  logic [5:0] step;
  logic [7:0] ir;
  logic [3:0] flags;
  logic       step_adv;
  logic [3:0] reg_en;
  logic [3:0] reg_set;
  logic       iar_en;
  logic       iar_set;
  logic       ram_en;
  logic       ram_set;
  logic       acc_en;
  logic       acc_set;
  logic       mar_set;
  logic       ir_set;
  logic       tmp_set;
  logic       flags_set;
  logic       bus1;
  logic [2:0] alu_op;
  logic       io_en;
  logic       io_set;
  logic       step_err;

  // The sequencer drives the control strobes; the datapath side consumes them
  modport master (
    input  step, ir, flags,
    output step_adv, reg_en, reg_set, iar_en, iar_set, ram_en, ram_set,
           acc_en, acc_set, mar_set, ir_set, tmp_set, flags_set, bus1,
           alu_op, io_en, io_set, step_err
  );

  modport slave (
    output step, ir, flags,
    input  step_adv, reg_en, reg_set, iar_en, iar_set, ram_en, ram_set,
           acc_en, acc_set, mar_set, ir_set, tmp_set, flags_set, bus1,
           alu_op, io_en, io_set, step_err
  );
endinterface
`default_nettype wire

// File: rtl/control_sequencer_phase_gen.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : phase_gen
// Phase counter splitting each step into N_PHASE clk phases.  Rev 1.0
// ------------------------------------------------------------------
module phase_gen #(
  parameter int N_PHASE   = 4,
  parameter int SET_PHASE = 2,
  localparam int PW       = $clog2(N_PHASE)
) (
  input  logic          clk,
  input  logic          reset,
  output logic [PW-1:0] phase_o,
  output logic          en_window_o,
  output logic          set_pulse_o,
  output logic          step_adv_o
);

  localparam logic [PW-1:0] LAST  = PW'(N_PHASE - 1);
  localparam logic [PW-1:0] SET_P = PW'(SET_PHASE);

  logic [PW-1:0] phase_q, phase_d;
  logic          step_adv_q;

  assign phase_d = (phase_q == LAST) ? '0 : phase_q + 1'b1;

  // Window/pulse qualify the phase about to start, so registered strobes line up with it
  assign en_window_o = (phase_d != '0) && (phase_d != LAST);
  assign set_pulse_o = (phase_d == SET_P);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      step_adv_q <= 1'b0;
    end else begin
      phase_q    <= phase_d;
      step_adv_q <= (phase_d == LAST);
    end
  end

  assign phase_o    = phase_q;
  assign step_adv_o = step_adv_q;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : control_sequencer
// Decodes {step, IR, flags} into phased enable/set strobes.  Rev 1.0
// ------------------------------------------------------------------
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int N_PHASE   = 4,
  parameter int SET_PHASE = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  control_sequencer_if.master        cs_bus
);

  localparam int PW = $clog2(N_PHASE);

  logic [PW-1:0] phase;
  logic          en_window;
  logic          set_pulse;
  logic          step_adv;

  logic [5:0] step_q, step_d;
  logic [7:0] ir_q, ir_d;
  logic [3:0] flags_q, flags_d;
  logic       err_q, err_d;
  ctrl_t      ctrl_q, ctrl_d;
  ctrl_t      dec;
  logic [2:0] op;
  logic [1:0] ra, rb;

  phase_gen #(
    .N_PHASE   (N_PHASE),
    .SET_PHASE (SET_PHASE)
  ) u_phase_gen (
    .clk         (clk),
    .reset       (reset),
    .phase_o     (phase),
    .en_window_o (en_window),
    .set_pulse_o (set_pulse),
    .step_adv_o  (step_adv)
  );

  always_comb begin
    step_d  = step_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    err_d   = err_q;
    if (phase == '0) begin
      step_d = cs_bus.step;
      ir_d   = cs_bus.ir;
      if (cs_bus.step == STEP6) flags_d = cs_bus.flags;
      if ((cs_bus.step != 6'd0) && !is_onehot6(cs_bus.step)) err_d = 1'b1;
    end
  end

  always_comb begin
    dec = '0;
    op  = ir_d[6:4];
    ra  = ir_d[3:2];
    rb  = ir_d[1:0];
    case (step_d)
      STEP1: begin
        dec.bus1 = 1'b1; dec.iar_en = 1'b1; dec.mar_set = 1'b1; dec.acc_set = 1'b1;
      end
      STEP2: begin dec.ram_en = 1'b1; dec.ir_set  = 1'b1; end
      STEP3: begin dec.acc_en = 1'b1; dec.iar_set = 1'b1; end
      STEP4: begin
        if (ir_d[7]) begin
          dec.reg_en[rb] = 1'b1; dec.tmp_set = 1'b1;
        end else begin
          case (op)
            OP_LOAD, OP_STORE: begin dec.reg_en[ra] = 1'b1; dec.mar_set = 1'b1; end
            OP_DATA, OP_JMPIF: begin
              dec.bus1 = 1'b1; dec.iar_en = 1'b1; dec.mar_set = 1'b1; dec.acc_set = 1'b1;
            end
            OP_JMPR: begin dec.reg_en[rb] = 1'b1; dec.iar_set = 1'b1; end
            OP_JMP:  begin dec.iar_en = 1'b1; dec.mar_set = 1'b1; end
            OP_CLF:  begin dec.bus1 = 1'b1; dec.flags_set = 1'b1; end
            default: begin
              if (ir_d[3]) begin dec.reg_en[rb] = 1'b1; dec.io_set = 1'b1; end
              else begin dec.io_en = 1'b1; dec.reg_set[rb] = 1'b1; end
            end
          endcase
        end
      end
      STEP5: begin
        if (ir_d[7]) begin
          dec.reg_en[ra] = 1'b1; dec.alu_op = op; dec.acc_set = 1'b1; dec.flags_set = 1'b1;
        end else begin
          case (op)
            OP_LOAD, OP_DATA: begin dec.ram_en = 1'b1; dec.reg_set[rb] = 1'b1; end
            OP_STORE: begin dec.reg_en[rb] = 1'b1; dec.ram_set = 1'b1; end
            OP_JMP:   begin dec.ram_en = 1'b1; dec.iar_set = 1'b1; end
            OP_JMPIF: begin dec.acc_en = 1'b1; dec.iar_set = 1'b1; end
            default: ;
          endcase
        end
      end
      STEP6: begin
        if (ir_d[7]) begin
          if (op != ALU_CMP) begin dec.acc_en = 1'b1; dec.reg_set[rb] = 1'b1; end
        end else begin
          case (op)
            OP_DATA: begin dec.acc_en = 1'b1; dec.iar_set = 1'b1; end
            // Conditional jump taken when any selected flag is set
            OP_JMPIF: begin
              if (|(ir_d[3:0] & flags_d)) begin dec.ram_en = 1'b1; dec.iar_set = 1'b1; end
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ctrl_d = '0;
    if (is_onehot6(step_d)) begin
      if (en_window) begin
        ctrl_d.reg_en = dec.reg_en;
        ctrl_d.iar_en = dec.iar_en;
        ctrl_d.ram_en = dec.ram_en;
        ctrl_d.acc_en = dec.acc_en;
        ctrl_d.io_en  = dec.io_en;
        ctrl_d.bus1   = dec.bus1;
        ctrl_d.alu_op = dec.alu_op;
      end
      if (set_pulse) begin
        ctrl_d.reg_set   = dec.reg_set;
        ctrl_d.iar_set   = dec.iar_set;
        ctrl_d.ram_set   = dec.ram_set;
        ctrl_d.acc_set   = dec.acc_set;
        ctrl_d.mar_set   = dec.mar_set;
        ctrl_d.ir_set    = dec.ir_set;
        ctrl_d.tmp_set   = dec.tmp_set;
        ctrl_d.flags_set = dec.flags_set;
        ctrl_d.io_set    = dec.io_set;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_q  <= '0;
      ir_q    <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      ctrl_q  <= '0;
    end else begin
      step_q  <= step_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
      err_q   <= err_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign cs_bus.step_adv  = step_adv;
  assign cs_bus.step_err  = err_q;
  assign cs_bus.reg_en    = ctrl_q.reg_en;
  assign cs_bus.reg_set   = ctrl_q.reg_set;
  assign cs_bus.iar_en    = ctrl_q.iar_en;
  assign cs_bus.iar_set   = ctrl_q.iar_set;
  assign cs_bus.ram_en    = ctrl_q.ram_en;
  assign cs_bus.ram_set   = ctrl_q.ram_set;
  assign cs_bus.acc_en    = ctrl_q.acc_en;
  assign cs_bus.acc_set   = ctrl_q.acc_set;
  assign cs_bus.mar_set   = ctrl_q.mar_set;
  assign cs_bus.ir_set    = ctrl_q.ir_set;
  assign cs_bus.tmp_set   = ctrl_q.tmp_set;
  assign cs_bus.flags_set = ctrl_q.flags_set;
  assign cs_bus.bus1      = ctrl_q.bus1;
  assign cs_bus.alu_op    = ctrl_q.alu_op;
  assign cs_bus.io_en     = ctrl_q.io_en;
  assign cs_bus.io_set    = ctrl_q.io_set;

endmodule
`default_nettype wire

// File: tb/tb_control_sequencer.sv
`default_nettype none
// ------------------------------------------------------------------
// Module : tb_control_sequencer
// Scoreboard bench for control_sequencer with a table-driven reference. Rev 1.0
// ------------------------------------------------------------------
module tb_control_sequencer;

  localparam int N  = 4;
  localparam int SP = 2;

  // Bit positions of the flattened output vector
  localparam int B_ADV = 25, B_ERR = 24, B_REN = 20, B_RSET = 16;
  localparam int B_IAR_EN = 15, B_IAR_SET = 14, B_RAM_EN = 13, B_RAM_SET = 12;
  localparam int B_ACC_EN = 11, B_ACC_SET = 10, B_MAR = 9, B_IR = 8, B_TMP = 7;
  localparam int B_FLG = 6, B_BUS1 = 5, B_ALU = 2, B_IO_EN = 1, B_IO_SET = 0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   err_model = 0;
  logic [25:0] exp_q[$];
  logic [25:0] act_vec;

  control_sequencer_if cs_if();

  control_sequencer #(.N_PHASE(N), .SET_PHASE(SP)) dut (
    .clk    (clk),
    .reset  (reset),
    .cs_bus (cs_if)
  );

  always #5 clk = ~clk;

  assign act_vec = {cs_if.step_adv, cs_if.step_err, cs_if.reg_en, cs_if.reg_set,
                    cs_if.iar_en, cs_if.iar_set, cs_if.ram_en, cs_if.ram_set,
                    cs_if.acc_en, cs_if.acc_set, cs_if.mar_set, cs_if.ir_set,
                    cs_if.tmp_set, cs_if.flags_set, cs_if.bus1, cs_if.alu_op,
                    cs_if.io_en, cs_if.io_set};

  // Micro-op table: enables live in the bus window, sets in the set phase
  function automatic void model(input int k, input logic [7:0] irv, input logic [3:0] fl,
                                output logic [25:0] en, output logic [25:0] st);
    int op, ra, rb;
    en = '0; st = '0;
    op = int'(irv[6:4]); ra = int'(irv[3:2]); rb = int'(irv[1:0]);
    if (k == 1) begin en[B_BUS1] = 1; en[B_IAR_EN] = 1; st[B_MAR] = 1; st[B_ACC_SET] = 1; end
    else if (k == 2) begin en[B_RAM_EN] = 1; st[B_IR] = 1; end
    else if (k == 3) begin en[B_ACC_EN] = 1; st[B_IAR_SET] = 1; end
    else if (irv[7]) begin
      if (k == 4) begin en[B_REN + rb] = 1; st[B_TMP] = 1; end
      if (k == 5) begin
        en[B_REN + ra] = 1; en[B_ALU +: 3] = irv[6:4]; st[B_ACC_SET] = 1; st[B_FLG] = 1;
      end
      if (k == 6 && op != 7) begin en[B_ACC_EN] = 1; st[B_RSET + rb] = 1; end
    end else begin
      case (op)
        0: begin
          if (k == 4) begin en[B_REN + ra] = 1; st[B_MAR] = 1; end
          if (k == 5) begin en[B_RAM_EN] = 1; st[B_RSET + rb] = 1; end
        end
        1: begin
          if (k == 4) begin en[B_REN + ra] = 1; st[B_MAR] = 1; end
          if (k == 5) begin en[B_REN + rb] = 1; st[B_RAM_SET] = 1; end
        end
        2: begin
          if (k == 4) begin en[B_BUS1] = 1; en[B_IAR_EN] = 1; st[B_MAR] = 1; st[B_ACC_SET] = 1; end
          if (k == 5) begin en[B_RAM_EN] = 1; st[B_RSET + rb] = 1; end
          if (k == 6) begin en[B_ACC_EN] = 1; st[B_IAR_SET] = 1; end
        end
        3: if (k == 4) begin en[B_REN + rb] = 1; st[B_IAR_SET] = 1; end
        4: begin
          if (k == 4) begin en[B_IAR_EN] = 1; st[B_MAR] = 1; end
          if (k == 5) begin en[B_RAM_EN] = 1; st[B_IAR_SET] = 1; end
        end
        5: begin
          if (k == 4) begin en[B_BUS1] = 1; en[B_IAR_EN] = 1; st[B_MAR] = 1; st[B_ACC_SET] = 1; end
          if (k == 5) begin en[B_ACC_EN] = 1; st[B_IAR_SET] = 1; end
          if (k == 6 && (irv[3:0] & fl) != 4'd0) begin en[B_RAM_EN] = 1; st[B_IAR_SET] = 1; end
        end
        6: if (k == 4) begin en[B_BUS1] = 1; st[B_FLG] = 1; end
        default: if (k == 4) begin
          if (irv[3]) begin en[B_REN + rb] = 1; st[B_IO_SET] = 1; end
          else begin en[B_IO_EN] = 1; st[B_RSET + rb] = 1; end
        end
      endcase
    end
  endfunction

  // Drive one step starting in phase 0; push expectations for the first n_push phases
  task automatic issue_step(input logic [5:0] st, input logic [7:0] irv, input logic [3:0] fl,
                            input int n_push);
    logic [25:0] en, sv, v;
    int k, err_before;
    k = 0;
    if ($countones(st) == 1)
      for (int i = 0; i < 6; i++) if (st[i]) k = 6 - i;
    model(k, irv, fl, en, sv);
    err_before = err_model;
    if (st != 6'd0 && $countones(st) != 1) err_model = 1;
    for (int p = 0; p < n_push; p++) begin
      v = '0;
      v[B_ERR] = (p == 0) ? err_before[0] : err_model[0];
      if (p >= 1 && p <= N - 2) v = v | en;
      if (p == SP) v = v | sv;
      if (p == N - 1) v[B_ADV] = 1'b1;
      exp_q.push_back(v);
    end
    cs_if.step = st; cs_if.ir = irv; cs_if.flags = fl;
    @(posedge clk); #1;
    cs_if.step = 6'($urandom); cs_if.ir = 8'($urandom); cs_if.flags = 4'($urandom);
  endtask

  task automatic run_step(input logic [5:0] st, input logic [7:0] irv, input logic [3:0] fl);
    issue_step(st, irv, fl, N);
    repeat (N - 1) @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [7:0] irv, input logic [3:0] fl);
    for (int k = 1; k <= 6; k++) run_step(6'b100000 >> (k - 1), irv, fl);
  endtask

  always @(negedge clk) begin
    if (!reset && exp_q.size() != 0) begin
      logic [25:0] e;
      e = exp_q.pop_front();
      checks++;
      if (act_vec !== e) begin
        errors++;
        $display("FAIL outputs t=%0t actual=%h required=%h", $time, act_vec, e);
      end
    end
  end

  initial begin
    cs_if.step = '0; cs_if.ir = '0; cs_if.flags = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (act_vec !== 26'd0) begin
      errors++;
      $display("FAIL reset_state actual=%h required=%h", act_vec, 26'd0);
    end
    @(posedge clk); #1 reset = 1'b0;

    run_step(6'b000000, 8'h00, 4'h0);
    run_step(6'b100000, 8'h86, 4'h0);
    run_step(6'b010000, 8'h86, 4'h0);
    run_instr(8'h86, 4'h0);
    run_instr(8'hF6, 4'h0);
    run_instr(8'h58, 4'b1000);
    run_instr(8'h58, 4'b0111);
    run_instr(8'h7B, 4'h0);
    run_instr(8'h71, 4'h0);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) run_step(6'b000000, 8'($urandom), 4'($urandom));
      run_instr(8'($urandom), 4'($urandom));
    end

    // Reset mid-step: LOAD R2->R1, reset in phase 2 of step5
    for (int k = 1; k <= 4; k++) run_step(6'b100000 >> (k - 1), 8'h09, 4'h0);
    issue_step(6'b000010, 8'h09, 4'h0, SP + 1);
    repeat (SP - 1) @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b1;
    err_model = 0;
    #1;
    checks++;
    if (act_vec !== 26'd0) begin
      errors++;
      $display("FAIL async_reset actual=%h required=%h", act_vec, 26'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_step(6'b000000, 8'h00, 4'h0);
    run_instr(8'h09, 4'h0);

    run_step(6'b000011, 8'h86, 4'hF);
    run_step(6'b000000, 8'h00, 4'h0);
    run_instr(8'h86, 4'h0);
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) run_step(6'b110000 | 6'($urandom), 8'($urandom), 4'($urandom));
      run_instr(8'($urandom), 4'($urandom));
    end

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
